// File: rtl/flash_seq_pkg.sv
// Shared types and default region constants for the flash read sequencer
// and the audio top level.
package flash_seq_pkg;

    localparam int DEF_ADDR_W = 23;

    typedef logic [DEF_ADDR_W-1:0] flash_addr_t;

    localparam flash_addr_t DEF_START_ADDR = 23'h0;
    localparam flash_addr_t DEF_END_ADDR   = 23'h7FFFF;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        HOLD,
        ADVANCE
    } seq_state_t;

endpackage

// File: rtl/flash_read_sequencer_if.sv
// Avalon-MM read port toward flash plus the word valid/ready stream toward audio_control.
interface flash_read_sequencer_if
    import flash_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              flash_read;
    logic [ADDR_W-1:0] flash_address;
    logic              flash_waitrequest;
    logic [31:0]       flash_readdata;
    logic              flash_readdatavalid;
    logic [31:0]       word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output flash_read, flash_address, word_data, word_valid,
        input  flash_waitrequest, flash_readdata, flash_readdatavalid, word_ready
    );

    modport slave (
        input  flash_read, flash_address, word_data, word_valid,
        output flash_waitrequest, flash_readdata, flash_readdatavalid, word_ready
    );

endinterface

// File: rtl/flash_addr_stepper.sv
// Combinational next flash address: restart jump, or one step in the
// current direction with wrap-around inside [START_ADDR, END_ADDR].
module flash_addr_stepper
    import flash_seq_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [ADDR_W-1:0] END_ADDR   = DEF_END_ADDR
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              forward,
    input  logic              restart,
    output logic [ADDR_W-1:0] addr_nxt
);

    always_comb begin
        // NOTE: default assignment first so every path drives addr_nxt and no latch is inferred.
        addr_nxt = addr;
        if (restart) begin
            addr_nxt = forward ? START_ADDR : END_ADDR;
        end else if (forward) begin
            addr_nxt = (addr == END_ADDR) ? START_ADDR : addr + ADDR_W'(1);
        end else begin
            addr_nxt = (addr == START_ADDR) ? END_ADDR : addr - ADDR_W'(1);
        end
    end

endmodule

// File: rtl/flash_read_sequencer.sv
// Fetches 32-bit audio words from flash one at a time and presents each to
// audio_control over valid/ready; owns address, direction, pause and restart.
module flash_read_sequencer
    import flash_seq_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [ADDR_W-1:0] END_ADDR   = DEF_END_ADDR
) (
    input  logic clk,
    input  logic reset_n,
    input  logic play,
    input  logic forward,
    input  logic restart,
    output logic busy,
    flash_read_sequencer_if.master bus
);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [31:0]       word_q;
    logic              restart_pend;
    logic              discard;

    // A restart seen now or earlier in this transaction cancels the word and jumps the address.
    assign discard = restart_pend | restart;

    flash_addr_stepper #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_stepper (
        .addr     (addr),
        .forward  (forward),
        .restart  (discard),
        .addr_nxt (addr_nxt)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (!restart && play)                state_nxt = REQ;
            REQ:       if (!bus.flash_waitrequest)           state_nxt = WAIT_DATA;
            WAIT_DATA: if (bus.flash_readdatavalid)         state_nxt = discard ? ADVANCE : HOLD;
            HOLD:      if (restart || bus.word_ready)        state_nxt = ADVANCE;
            ADVANCE:                                         state_nxt = play ? REQ : IDLE;
            default:                                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.flash_read = (state == REQ);
        bus.word_valid = (state == HOLD);
        busy           = (state == REQ) || (state == WAIT_DATA);
    end

    assign bus.flash_address = addr;
    assign bus.word_data     = word_q;

    // Address moves only on an idle restart or in ADVANCE, so it stays frozen while paused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr         <= START_ADDR;
            word_q       <= '0;
            restart_pend <= 1'b0;
        end else begin
            if ((state == IDLE && restart) || state == ADVANCE)
                addr <= addr_nxt;

            if (state == WAIT_DATA && bus.flash_readdatavalid)
                word_q <= bus.flash_readdata;

            if (state == ADVANCE)
                restart_pend <= 1'b0;
            else if (restart && (state == REQ || state == WAIT_DATA || state == HOLD))
                restart_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Self-checking bench: directed scenarios plus randomized play/direction/restart
// traffic against a transaction-phase reference model with modular address arithmetic.
module tb_flash_read_sequencer;
    import flash_seq_pkg::*;

    localparam logic [22:0] S_ADDR = DEF_START_ADDR;
    localparam logic [22:0] E_ADDR = DEF_END_ADDR;
    localparam int P_IDLE = 0, P_REQ = 1, P_WAIT = 2, P_HOLD = 3, P_ADV = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic play = 1'b0, forward = 1'b1, restart = 1'b0;
    logic busy;

    flash_read_sequencer_if #(.ADDR_W(DEF_ADDR_W)) bus ();

    flash_read_sequencer #(
        .ADDR_W     (DEF_ADDR_W),
        .START_ADDR (DEF_START_ADDR),
        .END_ADDR   (DEF_END_ADDR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .play    (play),
        .forward (forward),
        .restart (restart),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: transaction phase, current word address, last captured word, pending restart.
    int          m_phase;
    logic [22:0] m_addr;
    logic [31:0] m_word;
    bit          m_pend;
    int          lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [22:0] step(input logic [22:0] a, input bit fwd);
        longint span, off;
        span = longint'(E_ADDR) - longint'(S_ADDR) + 1;
        off  = longint'(a) - longint'(S_ADDR);
        off  = fwd ? (off + 1) % span : (off + span - 1) % span;
        return 23'(longint'(S_ADDR) + off);
    endfunction

    task automatic reset_model();
        m_phase = P_IDLE;
        m_addr  = S_ADDR;
        m_word  = '0;
        m_pend  = 1'b0;
        lat     = 0;
    endtask

    task automatic check_outputs();
        check("flash_read", 32'(bus.flash_read), 32'(m_phase == P_REQ));
        check("flash_address", 32'(bus.flash_address), 32'(m_addr));
        check("word_valid", 32'(bus.word_valid), 32'(m_phase == P_HOLD));
        check("word_data", bus.word_data, m_word);
        check("busy", 32'(busy), 32'(m_phase == P_REQ || m_phase == P_WAIT));
    endtask

    // Called at a negedge: check outputs, drive inputs for the next posedge, advance the model.
    task automatic cycle(input bit p, input bit f, input bit r, input bit rdy,
                         input bit wr, input bit rdv, input logic [31:0] d);
        bit jump;
        check_outputs();
        play = p; forward = f; restart = r;
        bus.word_ready          = rdy;
        bus.flash_waitrequest   = wr;
        bus.flash_readdatavalid = rdv;
        bus.flash_readdata      = d;
        jump = m_pend | r;
        case (m_phase)
            P_IDLE: begin
                if (r)      m_addr  = f ? S_ADDR : E_ADDR;
                else if (p) m_phase = P_REQ;
            end
            P_REQ: begin
                if (r)   m_pend  = 1'b1;
                if (!wr) m_phase = P_WAIT;
            end
            P_WAIT: begin
                if (r) m_pend = 1'b1;
                if (rdv) begin
                    m_word  = d;
                    m_phase = jump ? P_ADV : P_HOLD;
                end
            end
            P_HOLD: begin
                if (r) m_pend = 1'b1;
                if (r || rdy) m_phase = P_ADV;
            end
            default: begin
                m_addr  = jump ? (f ? S_ADDR : E_ADDR) : step(m_addr, f);
                m_pend  = 1'b0;
                m_phase = p ? P_REQ : P_IDLE;
            end
        endcase
        @(negedge clk);
    endtask

    // One complete fetch starting and ending in REQ with play held high.
    task automatic xact(input bit f, input logic [31:0] d);
        cycle(1, f, 0, 0, 0, 0, 32'h0);
        cycle(1, f, 0, 0, 0, 1, d);
        cycle(1, f, 0, 1, 0, 0, 32'h0);
        cycle(1, f, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        bit p, f, r, rdy, wr, rdv, was_req, fdir;
        logic [31:0] d;
        logic [22:0] frozen;

        bus.flash_waitrequest   = 1'b0;
        bus.flash_readdata      = '0;
        bus.flash_readdatavalid = 1'b0;
        bus.word_ready          = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check("rst_flash_read", 32'(bus.flash_read), 32'd0);
        check("rst_word_valid", 32'(bus.word_valid), 32'd0);
        check("rst_address", 32'(bus.flash_address), 32'(S_ADDR));

        // Basic fetch with two waitrequest cycles.
        cycle(1, 1, 0, 0, 0, 0, 32'h0);
        check("t2_read_up", 32'(bus.flash_read), 32'd1);
        cycle(1, 1, 0, 0, 1, 0, 32'h0);
        cycle(1, 1, 0, 0, 1, 0, 32'h0);
        check("t2_read_held", 32'(bus.flash_read), 32'd1);
        cycle(1, 1, 0, 0, 0, 0, 32'h0);
        cycle(1, 1, 0, 0, 0, 1, 32'h12345678);
        check("t2_word_data", bus.word_data, 32'h12345678);
        check("t2_word_valid", 32'(bus.word_valid), 32'd1);
        cycle(1, 1, 0, 1, 0, 0, 32'h0);
        cycle(1, 1, 0, 0, 1, 0, 32'h0);
        check("t2_next_addr", 32'(bus.flash_address), 32'd1);
        check("t2_next_read", 32'(bus.flash_read), 32'd1);

        repeat (4) xact(1, $urandom);
        check("t4_at_5", 32'(bus.flash_address), 32'd5);

        // Restart during WAIT_DATA going backward: word discarded, jump to END_ADDR.
        cycle(1, 0, 0, 0, 0, 0, 32'h0);
        cycle(1, 0, 1, 0, 0, 0, 32'h0);
        cycle(1, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        check("t4_no_valid", 32'(bus.word_valid), 32'd0);
        cycle(1, 0, 0, 0, 1, 0, 32'h0);
        check("t4_end_addr", 32'(bus.flash_address), 32'(E_ADDR));

        // Wrap forward past END_ADDR, then backward past START_ADDR.
        xact(1, $urandom);
        check("t3_wrap_fwd", 32'(bus.flash_address), 32'(S_ADDR));
        xact(0, $urandom);
        check("t3_wrap_back", 32'(bus.flash_address), 32'(E_ADDR));

        // Pause while the request is stalled; includes a spurious readdatavalid in HOLD.
        repeat (3) cycle(0, 1, 0, 0, 1, 0, 32'h0);
        check("t5_req_held", 32'(bus.flash_read), 32'd1);
        cycle(0, 1, 0, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 0, 1, 32'hCAFE0001);
        cycle(0, 1, 0, 0, 0, 0, 32'h0);
        check("t5_word_valid", 32'(bus.word_valid), 32'd1);
        cycle(0, 1, 0, 0, 0, 1, 32'hBAD0BAD0);
        check("t6_hold_data", bus.word_data, 32'hCAFE0001);
        check("t6_hold_valid", 32'(bus.word_valid), 32'd1);
        cycle(0, 1, 0, 1, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 0, 0, 32'h0);
        check("t5_idle_read", 32'(bus.flash_read), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        frozen = bus.flash_address;
        check("t5_idle_addr", 32'(frozen), 32'(S_ADDR));
        repeat (4) cycle(0, 0, 0, 0, 0, 1, $urandom);
        check("t6_idle_data", bus.word_data, 32'hCAFE0001);
        check("t5_frozen", 32'(bus.flash_address), 32'(frozen));

        // Randomized traffic with a well-behaved Avalon slave and random spurious strobes.
        fdir = 1'b1;
        lat  = 0;
        for (int i = 0; i < 3000; i++) begin
            p = ($urandom % 8) != 0;
            if ($urandom % 16 == 0) fdir = ~fdir;
            f   = fdir;
            r   = ($urandom % 25) == 0;
            rdy = $urandom % 2;
            wr  = ($urandom % 3) == 0;
            d   = $urandom;
            rdv = 1'b0;
            if (m_phase == P_WAIT) begin
                if (lat == 0) rdv = 1'b1;
                else          lat--;
            end else begin
                rdv = ($urandom % 10) == 0;
            end
            was_req = (m_phase == P_REQ);
            cycle(p, f, r, rdy, wr, rdv, d);
            if (was_req && !wr) lat = $urandom_range(0, 3);
        end

        // Drive into a stalled REQ, then reset asynchronously mid-request.
        for (int i = 0; i < 20 && m_phase != P_REQ; i++)
            cycle(1, 1, 0, 1, 1, m_phase == P_WAIT, $urandom);
        check("t1_in_req", 32'(bus.flash_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t1_rst_read", 32'(bus.flash_read), 32'd0);
        check("t1_rst_addr", 32'(bus.flash_address), 32'(S_ADDR));
        check("t1_rst_valid", 32'(bus.word_valid), 32'd0);
        check("t1_rst_busy", 32'(busy), 32'd0);
        reset_model();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(0, 1, 0, 0, 0, 1, 32'hFFFFFFFF);
        cycle(0, 1, 0, 0, 0, 0, 32'h0);
        check("t1_late_data", bus.word_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
